// File: rtl/ahb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_slave_pkg -- AHB-Lite encodings, FSM states, strobe decode
// Revision: 1.0
// ============================================================================
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Little-endian byte lanes; sizes wider than the bus clamp to full width,
    // and the offset is aligned down to the (clamped) transfer size.
    function automatic logic [7:0] size_strobe(input logic [2:0] hsize,
                                               input logic [2:0] offs,
                                               input logic [2:0] max_size);
        logic [2:0] sz;
        logic [7:0] mask;
        logic [2:0] base;
        sz = (hsize > max_size) ? max_size : hsize;
        case (sz)
            3'd0:    begin mask = 8'h01; base = offs;                 end
            3'd1:    begin mask = 8'h03; base = {offs[2:1], 1'b0};    end
            3'd2:    begin mask = 8'h0F; base = {offs[2], 2'b00};     end
            default: begin mask = 8'hFF; base = 3'd0;                 end
        endcase
        return mask << base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_slave_mem -- MEM_DEPTH x DATA_WIDTH array, byte-enable
//           write, registered (synchronous) read. Array contents are not reset.
// Revision: 1.0
// ============================================================================
module ahb_sram_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    localparam int c_AW      = $clog2(MEM_DEPTH),
    localparam int c_NB      = DATA_WIDTH / 8
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [c_NB-1:0]       we_strb_i,
    input  logic [c_AW-1:0]       waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [c_AW-1:0]       raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge hclk) begin
        for (int b = 0; b < c_NB; b++) begin
            if (we_strb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    // Read-before-write: a same-edge write is merged back in by the caller.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)  rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_slave -- AHB-Lite SRAM target with wait states and RAW
//           bypass. Define AHB_SRAM_SLAVE_ERROR_EN for two-cycle ERROR responses.
// Revision: 1.0
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hselx,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    output logic                  hready,
    output logic                  hresp,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata
);
    import ahb_sram_slave_pkg::*;

    localparam int         c_NBYTES  = DATA_WIDTH / 8;
    localparam int         c_OFFW    = $clog2(c_NBYTES);
    localparam int         c_IDXW    = ADDR_WIDTH - c_OFFW;
    localparam int         c_MEMAW   = $clog2(MEM_DEPTH);
    localparam logic [2:0] c_MAXSIZE = 3'(c_OFFW);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q;
    logic [c_MEMAW-1:0]    idx_q;
    logic [c_NBYTES-1:0]   strb_q;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [c_NBYTES-1:0]   byp_strb_q;

    logic                  w_accept, w_err, w_hready, w_hresp, w_wr_en;
    logic [c_IDXW-1:0]     w_idx_full;
    logic [c_MEMAW-1:0]    w_idx;
    logic [c_NBYTES-1:0]   w_strb;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_idx_full = haddr[ADDR_WIDTH-1:c_OFFW];
    assign w_idx      = c_MEMAW'(32'(w_idx_full) % 32'(MEM_DEPTH));
    assign w_strb     = c_NBYTES'(size_strobe(hsize, 3'(haddr[c_OFFW-1:0]), c_MAXSIZE));

`ifdef AHB_SRAM_SLAVE_ERROR_EN
    assign w_err   = (32'(w_idx_full) >= 32'(MEM_DEPTH)) || (hsize > c_MAXSIZE);
    assign w_hresp = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign w_err   = 1'b0;
    assign w_hresp = HRESP_OKAY;
`endif

    assign w_hready = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign w_accept = hselx && w_hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign w_wr_en  = (state_q == ST_DATA) && write_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef AHB_SRAM_SLAVE_ERROR_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: ;
        endcase
        // Any hready-high cycle closes the current data phase and may open the next.
        if (w_hready) begin
            if (!w_accept)            state_d = ST_IDLE;
            else if (w_err)           state_d = ST_ERR1;
            else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end
            else                      state_d = ST_DATA;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            strb_q     <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            byp_strb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                write_q    <= hwrite;
                idx_q      <= w_idx;
                strb_q     <= w_strb;
                // Memory read sees the pre-write word when both hit the same edge.
                byp_q      <= w_wr_en && (idx_q == w_idx);
                byp_data_q <= hwdata;
                byp_strb_q <= strb_q;
            end
        end
    end

    ahb_sram_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .we_strb_i (w_wr_en ? strb_q : '0),
        .waddr_i   (idx_q),
        .wdata_i   (hwdata),
        .re_i      (w_accept),
        .raddr_i   (w_idx),
        .rdata_o   (w_mem_rdata)
    );

    generate
        for (genvar b = 0; b < c_NBYTES; b++) begin : g_merge
            assign hrdata[8*b +: 8] = (byp_q && byp_strb_q[b]) ? byp_data_q[8*b +: 8]
                                                               : w_mem_rdata[8*b +: 8];
        end
    endgenerate

    assign hready = w_hready;
    assign hresp  = w_hresp;

endmodule
`default_nettype wire
